// File: rtl/load_store_unit.sv
// +--------------------------------------------------------------------------+
// | load_store_unit : memory-stage LSU, one bus transaction per load/store.  |
// | Optional bus-timeout abort enabled by the LSU_TIMEOUT_EN macro.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_be,
`ifdef LSU_TIMEOUT_EN
  output logic                  timeout,
`endif
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] c_SZ_B = 2'b00;
  localparam logic [1:0] c_SZ_H = 2'b01;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   read_data_q;
  logic                    bus_req_q;
  logic                    bus_we_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [DATA_WIDTH-1:0]   bus_wdata_q;
  logic [3:0]              bus_be_q;
  logic [2:0]              funct3_q;
  logic [1:0]              off_q;

  logic                    is_half;
  logic                    is_word;
  logic                    any_req;
  logic                    misaligned_d;
  logic                    accept_d;
  logic [3:0]              be_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic [DATA_WIDTH-1:0]   shifted_d;
  logic [DATA_WIDTH-1:0]   load_ext_d;

  // funct3 encodings 011/110/111 fall through to word size
  assign is_half = (funct3[1:0] == c_SZ_H);
  assign is_word = funct3[1];
  assign any_req = mem_read | mem_write;

  assign misaligned_d = (state_q == IDLE) && any_req &&
                        ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
  assign accept_d     = (state_q == IDLE) && any_req && !misaligned_d;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = write_data;
    if (funct3[1:0] == c_SZ_B) begin
      be_d    = 4'b0001 << addr[1:0];
      wdata_d = {4{write_data[7:0]}};
    end else if (is_half) begin
      be_d    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{write_data[15:0]}};
    end
  end

  assign shifted_d = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext_d = bus_rdata;
    case (funct3_q)
      3'b000:  load_ext_d = {{(DATA_WIDTH-8){shifted_d[7]}}, shifted_d[7:0]};
      3'b100:  load_ext_d = {{(DATA_WIDTH-8){1'b0}}, shifted_d[7:0]};
      3'b001:  load_ext_d = {{(DATA_WIDTH-16){shifted_d[15]}}, shifted_d[15:0]};
      3'b101:  load_ext_d = {{(DATA_WIDTH-16){1'b0}}, shifted_d[15:0]};
      default: load_ext_d = bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      read_data_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= 4'b0000;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write & ~mem_read;
            bus_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            bus_wdata_q <= wdata_d;
            bus_be_q    <= be_d;
            funct3_q    <= funct3;
            off_q       <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
            state_q     <= BUSY;
          end else if (misaligned_d && mem_read) begin
            read_data_q <= '0;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            if (!bus_we_q) begin
              read_data_q <= load_ext_d;
            end
            bus_req_q <= 1'b0;
            state_q   <= DONE;
`ifdef LSU_TIMEOUT_EN
          end else if (cnt_q == c_CNT_LAST) begin
            if (!bus_we_q) begin
              read_data_q <= '0;
            end
            bus_req_q <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        DONE: begin
          // the MEM stage still presents the completed instruction here
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign read_data  = read_data_q;
  assign stall      = accept_d || (state_q == BUSY);
  assign misaligned = misaligned_d;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;
`ifdef LSU_TIMEOUT_EN
  assign timeout    = timeout_q;
`endif

endmodule

`default_nettype wire
